execute_cycle: RTL and testbench

Execute stage of the 5-stage RISC-V core, directly downstream of the decode stage. Consumes the E-stage control and data bundle, applies forwarding, runs the ALU and branch-target adder, and resolves branches. Registers the results into the E→M pipeline register feeding the memory stage.

---
 rtl/execute_cycle.sv | 202 ++++++++++++++++++++
 tb/tb_execute_cycle.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RISC-V core: forwarding, ALU, branch resolution and the E->M register.
// Define EXECUTE_MUL_EN to enable the iterative 32-cycle shift-add multiplier (ALUControlE=100).
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        StallE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_res;
  logic [31:0] exec_res;
  logic        stall;
  logic        zero;

  logic        regwrite_m_q, regwrite_m_d;
  logic        memwrite_m_q, memwrite_m_d;
  logic        resultsrc_m_q, resultsrc_m_d;
  logic [4:0]  rd_m_q, rd_m_d;
  logic [31:0] aluresult_m_q, aluresult_m_d;
  logic [31:0] writedata_m_q, writedata_m_d;
  logic [31:0] pcplus4_m_q, pcplus4_m_d;

  function automatic logic [31:0] alu_op(input logic [2:0] ctl,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    case (ctl)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b101:  r = {31'd0, (sa < sb)};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Operand selection; the M-stage value fed back here is the registered one
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = aluresult_m_q;
      default: src_a = RD1_E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = aluresult_m_q;
      default: fwd_b = RD2_E;
    endcase
    src_b   = ALUSrcE ? Imm_Ext_E : fwd_b;
    alu_res = alu_op(ALUControlE, src_a, src_b);
  end

`ifdef EXECUTE_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    stall    = 1'b0;
    exec_res = alu_res;
    case (state_q)
      S_IDLE: begin
        if (ALUControlE == 3'b100) begin
          stall   = 1'b1;
          mul_a_d = src_a;
          mul_b_d = src_b;
          acc_d   = 32'd0;
          cnt_d   = 5'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (mul_b_q[cnt_q]) acc_d = acc_q + (mul_a_q << cnt_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        exec_res = acc_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
    mul_a_q <= mul_a_d;
    mul_b_q <= mul_b_d;
  end
`else
  always_comb begin
    stall    = 1'b0;
    exec_res = alu_res;
  end
`endif

  // Branch resolution; Zero cannot assert while a multiply is still in flight
  always_comb begin
    zero      = !stall && (exec_res == 32'd0);
    PCSrcE    = BranchE & zero;
    PCTargetE = PCE + Imm_Ext_E;
    StallE    = stall;
  end

  // E->M register: bubble control and hold data while stalled
  always_comb begin
    regwrite_m_d  = 1'b0;
    memwrite_m_d  = 1'b0;
    resultsrc_m_d = 1'b0;
    rd_m_d        = rd_m_q;
    aluresult_m_d = aluresult_m_q;
    writedata_m_d = writedata_m_q;
    pcplus4_m_d   = pcplus4_m_q;
    if (!stall) begin
      regwrite_m_d  = RegWriteE;
      memwrite_m_d  = MemWriteE;
      resultsrc_m_d = ResultSrcE;
      rd_m_d        = RD_E;
      aluresult_m_d = exec_res;
      writedata_m_d = fwd_b;
      pcplus4_m_d   = PCPlus4E;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_m_q  <= 1'b0;
      memwrite_m_q  <= 1'b0;
      resultsrc_m_q <= 1'b0;
      rd_m_q        <= 5'd0;
      aluresult_m_q <= 32'd0;
      writedata_m_q <= 32'd0;
      pcplus4_m_q   <= 32'd0;
    end else begin
      regwrite_m_q  <= regwrite_m_d;
      memwrite_m_q  <= memwrite_m_d;
      resultsrc_m_q <= resultsrc_m_d;
      rd_m_q        <= rd_m_d;
      aluresult_m_q <= aluresult_m_d;
      writedata_m_q <= writedata_m_d;
      pcplus4_m_q   <= pcplus4_m_d;
    end
  end

  assign RegWriteM  = regwrite_m_q;
  assign MemWriteM  = memwrite_m_q;
  assign ResultSrcM = resultsrc_m_q;
  assign RD_M       = rd_m_q;
  assign ALUResultM = aluresult_m_q;
  assign WriteDataM = writedata_m_q;
  assign PCPlus4M   = pcplus4_m_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle; multiply scenarios build only with EXECUTE_MUL_EN.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE, StallE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;

  int total = 0;
  int bad   = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic defaults();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0;
    PCPlus4E = 0; RD_E = 0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    defaults();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD1_E = 32'h11; RD2_E = 32'h22;
    RD_E = 5'd9; PCPlus4E = 32'h44;
    tick();
    rst = 1;
    RD1_E = 32'h33;
    tick();
    rst = 0;
    total++; if (ALUResultM !== 32'd0) begin bad++; $display("FAIL reset_alu got=%h exp=0", ALUResultM); end
    total++; if ({RegWriteM, MemWriteM, ResultSrcM} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b exp=000", {RegWriteM, MemWriteM, ResultSrcM}); end
    total++; if ({RD_M, WriteDataM, PCPlus4M} !== 69'd0) begin bad++; $display("FAIL reset_data got=%h %h %h exp=0", RD_M, WriteDataM, PCPlus4M); end
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", StallE); end
  endtask

  task automatic test_alu();
    defaults();
    RegWriteE = 1; RD_E = 5'd3; PCPlus4E = 32'h1004;
    ALUControlE = 3'b001; RD1_E = 7; RD2_E = 5;
    tick();
    total++; if (ALUResultM !== 32'd2) begin bad++; $display("FAIL sub_pos got=%h exp=2", ALUResultM); end
    total++; if ({RegWriteM, RD_M, PCPlus4M} !== {1'b1, 5'd3, 32'h1004}) begin bad++; $display("FAIL passthru got=%b %h %h", RegWriteM, RD_M, PCPlus4M); end
    RD1_E = 5; RD2_E = 7;
    tick();
    total++; if (ALUResultM !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub_neg got=%h exp=fffffffe", ALUResultM); end
    ALUControlE = 3'b101; RD1_E = 32'hFFFFFFFF; RD2_E = 1;
    tick();
    total++; if (ALUResultM !== 32'd1) begin bad++; $display("FAIL slt_signed got=%h exp=1", ALUResultM); end
    RD1_E = 1; RD2_E = 32'hFFFFFFFF;
    tick();
    total++; if (ALUResultM !== 32'd0) begin bad++; $display("FAIL slt_false got=%h exp=0", ALUResultM); end
    ALUControlE = 3'b000; RD1_E = 32'hFFFFFFFF; RD2_E = 1;
    tick();
    total++; if (ALUResultM !== 32'd0) begin bad++; $display("FAIL add_wrap got=%h exp=0", ALUResultM); end
    ALUControlE = 3'b010; RD1_E = 32'hF0F0_1234; RD2_E = 32'h0FF0_FF00;
    tick();
    total++; if (ALUResultM !== 32'h00F0_1200) begin bad++; $display("FAIL and got=%h exp=00f01200", ALUResultM); end
    ALUControlE = 3'b011;
    tick();
    total++; if (ALUResultM !== 32'hFFF0_FF34) begin bad++; $display("FAIL or got=%h exp=fff0ff34", ALUResultM); end
    ALUControlE = 3'b110; RD1_E = 32'h5; RD2_E = 32'h6;
    tick();
    total++; if (ALUResultM !== 32'd0) begin bad++; $display("FAIL undef_op got=%h exp=0", ALUResultM); end
    ALUControlE = 3'b000; ALUSrcE = 1; RD1_E = 32'h10; RD2_E = 32'h999; Imm_Ext_E = 32'h8;
    tick();
    total++; if (ALUResultM !== 32'h18) begin bad++; $display("FAIL add_imm got=%h exp=18", ALUResultM); end
    total++; if (WriteDataM !== 32'h999) begin bad++; $display("FAIL store_data_imm got=%h exp=999", WriteDataM); end
  endtask

  task automatic test_branch();
    defaults();
    BranchE = 1; ALUControlE = 3'b001; RD1_E = 9; RD2_E = 9; PCE = 32'h100; Imm_Ext_E = 32'h20;
    #1;
    total++; if (PCSrcE !== 1'b1) begin bad++; $display("FAIL beq_taken got=%b exp=1", PCSrcE); end
    total++; if (PCTargetE !== 32'h120) begin bad++; $display("FAIL pc_target got=%h exp=120", PCTargetE); end
    RD2_E = 8;
    #1;
    total++; if (PCSrcE !== 1'b0) begin bad++; $display("FAIL beq_not_taken got=%b exp=0", PCSrcE); end
    RD2_E = 9; BranchE = 0;
    #1;
    total++; if (PCSrcE !== 1'b0) begin bad++; $display("FAIL no_branch got=%b exp=0", PCSrcE); end
    PCE = 32'hFFFF_FFF0;
    #1;
    total++; if (PCTargetE !== 32'h10) begin bad++; $display("FAIL pc_target_wrap got=%h exp=10", PCTargetE); end
    tick();
  endtask

  task automatic test_forward();
    defaults();
    RD1_E = 32'h40;
    tick();
    total++; if (ALUResultM !== 32'h40) begin bad++; $display("FAIL fwd_setup got=%h exp=40", ALUResultM); end
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 3; RD1_E = 32'hAAAA; RD2_E = 32'hBBBB;
    MemWriteE = 1;
    tick();
    total++; if (ALUResultM !== 32'h43) begin bad++; $display("FAIL fwd_alu got=%h exp=43", ALUResultM); end
    total++; if (WriteDataM !== 32'd3) begin bad++; $display("FAIL fwd_store got=%h exp=3", WriteDataM); end
    total++; if (MemWriteM !== 1'b1) begin bad++; $display("FAIL memwrite got=%b exp=1", MemWriteM); end
    ForwardAE = 2'b11; ForwardBE = 2'b10; ResultSrcE = 1;
    tick();
    total++; if (ALUResultM !== 32'hAAED) begin bad++; $display("FAIL fwd_11_10 got=%h exp=aaed", ALUResultM); end
    total++; if ({WriteDataM, ResultSrcM} !== {32'h43, 1'b1}) begin bad++; $display("FAIL fwd_store_m got=%h %b exp=43 1", WriteDataM, ResultSrcM); end
  endtask

  task automatic test_back_to_back();
    defaults();
    RegWriteE = 1; RD_E = 5'd1; RD1_E = 1; RD2_E = 2;
    tick();
    total++; if ({ALUResultM, RD_M} !== {32'd3, 5'd1}) begin bad++; $display("FAIL b2b_first got=%h %h exp=3 1", ALUResultM, RD_M); end
    ALUControlE = 3'b001; RD_E = 5'd2; RD1_E = 10; RD2_E = 4;
    tick();
    total++; if ({ALUResultM, RD_M} !== {32'd6, 5'd2}) begin bad++; $display("FAIL b2b_second got=%h %h exp=6 2", ALUResultM, RD_M); end
  endtask

`ifdef EXECUTE_MUL_EN
  task automatic test_mul();
    int n;
    defaults();
    RD1_E = 32'h1234;
    tick();
    RegWriteE = 1; RD_E = 5'd7; ALUControlE = 3'b100; RD1_E = 32'h10000; RD2_E = 32'h10001;
    #1;
    n = 0;
    while (StallE === 1'b1 && n < 40) begin
      n++;
      if (RegWriteM !== 1'b0) begin
        total++; bad++; $display("FAIL mul_bubble got=%b exp=0 cycle=%0d", RegWriteM, n);
      end
      if (n == 5) begin ForwardAE = 2'b01; ResultW = 32'd0; end
      tick();
    end
    total++; if (n !== 33) begin bad++; $display("FAIL mul_stall_len got=%0d exp=33", n); end
    total++; if (ALUResultM !== 32'h1234) begin bad++; $display("FAIL mul_hold got=%h exp=1234", ALUResultM); end
    tick();
    ALUControlE = 3'b000; ForwardAE = 2'b00;
    total++; if (ALUResultM !== 32'h0001_0000) begin bad++; $display("FAIL mul_result got=%h exp=00010000", ALUResultM); end
    total++; if ({RegWriteM, RD_M} !== {1'b1, 5'd7}) begin bad++; $display("FAIL mul_ctl got=%b %h exp=1 7", RegWriteM, RD_M); end
    #1;
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL mul_idle got=%b exp=0", StallE); end
    tick();
  endtask

  task automatic test_mul_reset();
    defaults();
    RegWriteE = 1; ALUControlE = 3'b100; RD1_E = 32'h3; RD2_E = 32'h5;
    tick();
    repeat (9) tick();
    total++; if (StallE !== 1'b1) begin bad++; $display("FAIL mulrst_busy got=%b exp=1", StallE); end
    rst = 1; ALUControlE = 3'b000; RD1_E = 2; RD2_E = 3;
    tick();
    rst = 0;
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL mulrst_stall got=%b exp=0", StallE); end
    total++; if ({ALUResultM, RegWriteM} !== 33'd0) begin bad++; $display("FAIL mulrst_m got=%h %b exp=0", ALUResultM, RegWriteM); end
    tick();
    total++; if ({ALUResultM, StallE} !== {32'd5, 1'b0}) begin bad++; $display("FAIL mulrst_after got=%h %b exp=5 0", ALUResultM, StallE); end
  endtask
`else
  task automatic test_mul();
    defaults();
    RegWriteE = 1; ALUControlE = 3'b100; RD1_E = 3; RD2_E = 4;
    #1;
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL nomul_stall got=%b exp=0", StallE); end
    tick();
    total++; if ({ALUResultM, RegWriteM} !== {32'd0, 1'b1}) begin bad++; $display("FAIL nomul_result got=%h %b exp=0 1", ALUResultM, RegWriteM); end
  endtask

  task automatic test_mul_reset();
    defaults();
    RD1_E = 4; RD2_E = 4; ALUControlE = 3'b011;
    tick();
    rst = 1;
    tick();
    rst = 0;
    total++; if ({ALUResultM, StallE} !== 33'd0) begin bad++; $display("FAIL nomul_reset got=%h %b exp=0", ALUResultM, StallE); end
  endtask
`endif

  initial begin
    defaults();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    test_reset();
    test_alu();
    test_branch();
    test_forward();
    test_back_to_back();
    test_mul();
    test_mul_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
